// File: rtl/pma_region_table.sv
`default_nettype none
// ============================================================================
// pma_region_table : programmable PMA rule table with a one-rule-per-cycle
//                    lookup engine returning OR-ed attributes of matching rules
// Revision: 1.0
// ============================================================================
module pma_region_table #(
    parameter int NrRules   = 4,
    parameter int AddrWidth = 64,
    parameter int IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [IdxWidth-1:0]  cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_gnt_o,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lkp_valid_i,
    output logic                 lkp_ready_o,
    input  logic [AddrWidth-1:0] lkp_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic                 rsp_cacheable_o,
    output logic                 rsp_executable_o,
    output logic                 rsp_nonidem_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [AddrWidth-1:0] rule_base [NrRules];
    logic [AddrWidth-1:0] rule_len  [NrRules];
    logic [3:0]           rule_attr [NrRules];   // {nonidem, exec, cache, valid}

    logic [AddrWidth-1:0] lkp_addr;
    logic [IdxWidth-1:0]  scan_idx;
    logic                 acc_hit, acc_cache, acc_exec, acc_nonidem;

    logic                 cfg_illegal;
    logic [AddrWidth-1:0] cfg_rd_val;
    logic [AddrWidth-1:0] sel_base, sel_len;
    logic [3:0]           sel_attr;
    logic                 rule_match;
    logic                 last_idx;

    assign cfg_illegal = (32'(cfg_idx_i) >= 32'(NrRules)) || (cfg_field_i == 2'd3);
    assign last_idx    = (scan_idx == IdxWidth'(NrRules - 1));

    always_comb begin
        cfg_rd_val = '0;
        sel_base   = '0;
        sel_len    = '0;
        sel_attr   = '0;
        for (int i = 0; i < NrRules; i++) begin
            if (cfg_idx_i == IdxWidth'(i)) begin
                case (cfg_field_i)
                    2'd0:    cfg_rd_val = rule_base[i];
                    2'd1:    cfg_rd_val = rule_len[i];
                    2'd2:    cfg_rd_val = {{(AddrWidth-4){1'b0}}, rule_attr[i]};
                    default: cfg_rd_val = '0;
                endcase
            end
            if (scan_idx == IdxWidth'(i)) begin
                sel_base = rule_base[i];
                sel_len  = rule_len[i];
                sel_attr = rule_attr[i];
            end
        end
    end

    // One extra bit keeps base+len from wrapping at the top of the address space.
    assign rule_match = sel_attr[0]
                     && ({1'b0, lkp_addr} >= {1'b0, sel_base})
                     && ({1'b0, lkp_addr} <  ({1'b0, sel_base} + {1'b0, sel_len}));

    always_comb begin
        state_next  = state;
        cfg_gnt_o   = 1'b0;
        lkp_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                cfg_gnt_o   = cfg_req_i;
                lkp_ready_o = !cfg_req_i;
                if (lkp_valid_i && !cfg_req_i) state_next = SCAN;
            end
            SCAN: begin
                if (last_idx) state_next = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rsp_hit_o        = rsp_valid_o & acc_hit;
    assign rsp_cacheable_o  = rsp_valid_o & acc_cache;
    assign rsp_executable_o = rsp_valid_o & acc_exec;
    assign rsp_nonidem_o    = rsp_valid_o & acc_nonidem;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrRules; i++) begin
                rule_base[i] <= '0;
                rule_len[i]  <= '0;
                rule_attr[i] <= '0;
            end
        end else if (cfg_gnt_o && cfg_we_i && !cfg_illegal) begin
            for (int i = 0; i < NrRules; i++) begin
                if (cfg_idx_i == IdxWidth'(i)) begin
                    case (cfg_field_i)
                        2'd0:    rule_base[i] <= cfg_wdata_i;
                        2'd1:    rule_len[i]  <= cfg_wdata_i;
                        2'd2:    rule_attr[i] <= cfg_wdata_i[3:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Legal writes are silent; reads and any illegal access get a response beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_rvalid_o <= 1'b0;
            cfg_err_o    <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_gnt_o && (!cfg_we_i || cfg_illegal);
            cfg_err_o    <= cfg_gnt_o && cfg_illegal;
            cfg_rdata_o  <= (cfg_gnt_o && !cfg_we_i && !cfg_illegal) ? cfg_rd_val : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lkp_addr    <= '0;
            scan_idx    <= '0;
            acc_hit     <= 1'b0;
            acc_cache   <= 1'b0;
            acc_exec    <= 1'b0;
            acc_nonidem <= 1'b0;
        end else if (state == IDLE && lkp_valid_i && lkp_ready_o) begin
            lkp_addr    <= lkp_addr_i;
            scan_idx    <= '0;
            acc_hit     <= 1'b0;
            acc_cache   <= 1'b0;
            acc_exec    <= 1'b0;
            acc_nonidem <= 1'b0;
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            if (rule_match) begin
                acc_hit     <= 1'b1;
                acc_cache   <= acc_cache   | sel_attr[1];
                acc_exec    <= acc_exec    | sel_attr[2];
                acc_nonidem <= acc_nonidem | sel_attr[3];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pma_region_table.sv
`default_nettype none
// ============================================================================
// tb_pma_region_table : directed self-checking bench for pma_region_table
// Revision: 1.0
// ============================================================================
module tb_pma_region_table;

    localparam int NR = 4;
    localparam int AW = 64;
    localparam int IW = 3;   // one spare index bit so idx == NR can be driven

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_req, cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [1:0]    cfg_field;
    logic [AW-1:0] cfg_wdata;
    logic          cfg_gnt, cfg_rvalid, cfg_err;
    logic [AW-1:0] cfg_rdata;
    logic          lkp_valid, lkp_ready;
    logic [AW-1:0] lkp_addr;
    logic          rsp_valid, rsp_ready;
    logic          rsp_hit, rsp_cache, rsp_exec, rsp_nonidem;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pma_region_table #(.NrRules(NR), .AddrWidth(AW), .IdxWidth(IW)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_field_i(cfg_field), .cfg_wdata_i(cfg_wdata),
        .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata),
        .cfg_err_o(cfg_err),
        .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_addr_i(lkp_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_hit_o(rsp_hit), .rsp_cacheable_o(rsp_cache),
        .rsp_executable_o(rsp_exec), .rsp_nonidem_o(rsp_nonidem)
    );

    task automatic cfg_write(input logic [IW-1:0] idx, input logic [1:0] fld,
                             input logic [AW-1:0] d);
        @(posedge clk); #1;
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_idx = idx; cfg_field = fld; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_req = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [IW-1:0] idx, input logic [1:0] fld,
                            output logic [AW-1:0] d, output logic v, output logic e);
        @(posedge clk); #1;
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_idx = idx; cfg_field = fld;
        @(posedge clk); #1;
        cfg_req = 1'b0;
        d = cfg_rdata; v = cfg_rvalid; e = cfg_err;
    endtask

    // lat counts clock edges from the accepting edge up to the first RESP cycle.
    task automatic lookup(input logic [AW-1:0] a, output logic [3:0] r, output int lat);
        @(posedge clk); #1;
        lkp_valid = 1'b1; lkp_addr = a; lat = 0;
        do begin
            @(posedge clk); #1;
            lkp_valid = 1'b0;
            lat++;
        end while (!rsp_valid && lat < 50);
        r = {rsp_hit, rsp_cache, rsp_exec, rsp_nonidem};
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW-1:0] d; logic v, e;
        rst = 1'b1; cfg_req = 0; cfg_we = 0; cfg_idx = '0; cfg_field = '0;
        cfg_wdata = '0; lkp_valid = 0; lkp_addr = '0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (lkp_ready !== 1'b1) begin fails++; $display("FAIL reset_lkp_ready got %b exp 1", lkp_ready); end
        checks++; if ({rsp_valid, cfg_gnt, cfg_rvalid, cfg_err} !== 4'b0) begin fails++; $display("FAIL reset_outputs got %b exp 0000", {rsp_valid, cfg_gnt, cfg_rvalid, cfg_err}); end
        cfg_read(3'd0, 2'd2, d, v, e);
        checks++; if ({v, e, d} !== {1'b1, 1'b0, 64'h0}) begin fails++; $display("FAIL reset_rule0_attr got v=%b e=%b d=%h exp v=1 e=0 d=0", v, e, d); end
    endtask

    task automatic test_empty_lookup();
        logic [3:0] r; int lat;
        lookup(64'h8000_0000, r, lat);
        checks++; if (lat != NR + 1) begin fails++; $display("FAIL empty_latency got %0d exp %0d", lat, NR + 1); end
        checks++; if (r !== 4'b0000) begin fails++; $display("FAIL empty_result got %b exp 0000", r); end
    endtask

    task automatic test_single_rule();
        logic [3:0] r; int lat; logic [AW-1:0] d; logic v, e;
        cfg_write(3'd0, 2'd0, 64'h8000_0000);
        checks++; if (cfg_rvalid !== 1'b0) begin fails++; $display("FAIL legal_write_rvalid got %b exp 0", cfg_rvalid); end
        cfg_write(3'd0, 2'd1, 64'h1000_0000);
        cfg_write(3'd0, 2'd2, 64'hFFFF_FFF7);   // only [3:0] is stored
        cfg_read(3'd0, 2'd2, d, v, e);
        checks++; if ({v, e, d} !== {1'b1, 1'b0, 64'h7}) begin fails++; $display("FAIL attr_readback got v=%b e=%b d=%h exp v=1 e=0 d=7", v, e, d); end
        cfg_read(3'd0, 2'd1, d, v, e);
        checks++; if (d !== 64'h1000_0000) begin fails++; $display("FAIL len_readback got %h exp 10000000", d); end
        lookup(64'h8FFF_FFFF, r, lat);
        checks++; if (r !== 4'b1110) begin fails++; $display("FAIL rule0_last_byte got %b exp 1110", r); end
        lookup(64'h9000_0000, r, lat);
        checks++; if (r !== 4'b0000) begin fails++; $display("FAIL rule0_end_excl got %b exp 0000", r); end
        lookup(64'h7FFF_FFFF, r, lat);
        checks++; if (r !== 4'b0000) begin fails++; $display("FAIL rule0_below_base got %b exp 0000", r); end
    endtask

    task automatic test_overlap();
        logic [3:0] r; int lat;
        cfg_write(3'd1, 2'd0, 64'h8000_0000);
        cfg_write(3'd1, 2'd1, 64'h100);
        cfg_write(3'd1, 2'd2, 64'h9);
        lookup(64'h8000_0010, r, lat);
        checks++; if (r !== 4'b1111) begin fails++; $display("FAIL overlap_or got %b exp 1111", r); end
        lookup(64'h8000_0100, r, lat);
        checks++; if (r !== 4'b1110) begin fails++; $display("FAIL overlap_rule1_end got %b exp 1110", r); end
    endtask

    task automatic test_top_of_space();
        logic [3:0] r; int lat;
        cfg_write(3'd2, 2'd0, 64'hFFFF_FFFF_FFFF_F000);
        cfg_write(3'd2, 2'd1, 64'h1000);
        cfg_write(3'd2, 2'd2, 64'h3);
        cfg_write(3'd3, 2'd0, 64'h0);
        cfg_write(3'd3, 2'd1, 64'h0);
        cfg_write(3'd3, 2'd2, 64'hF);
        lookup(64'hFFFF_FFFF_FFFF_FFFF, r, lat);
        checks++; if (r !== 4'b1100) begin fails++; $display("FAIL top_addr got %b exp 1100", r); end
        lookup(64'hFFFF_FFFF_FFFF_EFFF, r, lat);
        checks++; if (r !== 4'b0000) begin fails++; $display("FAIL top_below_base got %b exp 0000", r); end
        lookup(64'h0, r, lat);
        checks++; if (r !== 4'b0000) begin fails++; $display("FAIL zero_len_rule got %b exp 0000", r); end
    endtask

    task automatic test_priority_and_stall();
        logic [3:0] r0; int n;
        @(posedge clk); #1;
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_field = 2'd0;
        lkp_valid = 1'b1; lkp_addr = 64'h8000_0000;
        #1;
        checks++; if ({cfg_gnt, lkp_ready} !== 2'b10) begin fails++; $display("FAIL cfg_priority got gnt=%b rdy=%b exp gnt=1 rdy=0", cfg_gnt, lkp_ready); end
        @(posedge clk); #1;
        cfg_req = 1'b0;
        checks++; if ({cfg_rvalid, cfg_rdata} !== {1'b1, 64'h8000_0000}) begin fails++; $display("FAIL prio_read got v=%b d=%h exp v=1 d=80000000", cfg_rvalid, cfg_rdata); end
        @(posedge clk); #1;   // lookup accepted at this edge
        lkp_valid = 1'b0;
        cfg_req = 1'b1;
        #1;
        checks++; if ({cfg_gnt, lkp_ready} !== 2'b00) begin fails++; $display("FAIL scan_no_gnt got gnt=%b rdy=%b exp 00", cfg_gnt, lkp_ready); end
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (n != NR) begin fails++; $display("FAIL stall_reach_resp got %0d exp %0d", n, NR); end
        r0 = {rsp_hit, rsp_cache, rsp_exec, rsp_nonidem};
        checks++; if (r0 !== 4'b1111) begin fails++; $display("FAIL stall_result got %b exp 1111", r0); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, cfg_gnt, rsp_hit, rsp_cache, rsp_exec, rsp_nonidem} !== 6'b10_1111) begin
                fails++;
                $display("FAIL stall_hold_%0d got v=%b gnt=%b r=%b exp v=1 gnt=0 r=1111", k, rsp_valid, cfg_gnt, {rsp_hit, rsp_cache, rsp_exec, rsp_nonidem});
            end
        end
        cfg_req = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if ({rsp_valid, lkp_ready} !== 2'b01) begin fails++; $display("FAIL stall_release got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, lkp_ready); end
    endtask

    task automatic test_illegal();
        logic [AW-1:0] d; logic v, e;
        cfg_write(3'd4, 2'd0, 64'h1234);
        checks++; if ({cfg_rvalid, cfg_err} !== 2'b11) begin fails++; $display("FAIL bad_idx_write got v=%b e=%b exp 11", cfg_rvalid, cfg_err); end
        cfg_write(3'd0, 2'd3, 64'h1234);
        checks++; if ({cfg_rvalid, cfg_err} !== 2'b11) begin fails++; $display("FAIL field3_write got v=%b e=%b exp 11", cfg_rvalid, cfg_err); end
        cfg_read(3'd4, 2'd0, d, v, e);
        checks++; if ({v, e, d} !== {2'b11, 64'h0}) begin fails++; $display("FAIL bad_idx_read got v=%b e=%b d=%h exp v=1 e=1 d=0", v, e, d); end
        cfg_read(3'd0, 2'd0, d, v, e);
        checks++; if ({v, e, d} !== {2'b10, 64'h8000_0000}) begin fails++; $display("FAIL no_state_change got v=%b e=%b d=%h exp v=1 e=0 d=80000000", v, e, d); end
        @(posedge clk); #1;
        checks++; if (cfg_rvalid !== 1'b0) begin fails++; $display("FAIL rvalid_pulse got %b exp 0", cfg_rvalid); end
    endtask

    task automatic test_reset_mid_scan();
        logic [AW-1:0] d; logic v, e; logic seen;
        @(posedge clk); #1;
        lkp_valid = 1'b1; lkp_addr = 64'h8000_0000;
        @(posedge clk); #1;
        lkp_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if ({rsp_valid, lkp_ready} !== 2'b01) begin fails++; $display("FAIL midscan_reset got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, lkp_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (NR + 3) begin @(posedge clk); #1; seen = seen | rsp_valid; end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL midscan_no_rsp got %b exp 0", seen); end
        cfg_read(3'd0, 2'd2, d, v, e);
        checks++; if (d !== 64'h0) begin fails++; $display("FAIL rules_cleared got %h exp 0", d); end
    endtask

    initial begin
        test_reset();
        test_empty_lookup();
        test_single_rule();
        test_overlap();
        test_top_of_space();
        test_priority_and_stall();
        test_illegal();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
